job_dispatcher: RTL and testbench
=================================

# job_dispatcher

Host-side loader that sits directly upstream of the SHA design core. Buffers one mining job (8 midstate words followed by 16 header words) written by the host, then streams it into the core with a `start_found` pulse and 24 `shift_in_enable` strobes. It then waits for the core's `sol_claim`, captures the golden nonce and solve latency, acknowledges the core with `sol_response`, and holds the result for the host.

## Interface
Parameters:
- `MID_WORDS`, 8: midstate words, shifted first.
- `HEAD_WORDS`, 16: header words, shifted after the midstate words.
- `SHIFT_GAP`, 0: idle cycles inserted between consecutive shift strobes (0 = back-to-back).

Ports:
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  host write strobe for one job word.
- `wr_data`  in  32  job word; written in order at index `wr_count`.
- `wr_count`  out  5  number of words buffered, 0..24.
- `buf_full`  out  1  high when `wr_count == MID_WORDS+HEAD_WORDS`.
- `job_go`  in  1  host request to dispatch the buffered job.
- `abort`  in  1  synchronous abort; returns to IDLE from any state.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  a nonce result is held.
- `result_nonce`  out  32  captured golden nonce.
- `result_cycles`  out  32  cycles from the last shift strobe to `sol_claim`.
- `result_ack`  in  1  host consumes the result.
- `start_found`  out  1  one-cycle job-start pulse to the core.
- `shift_in_enable`  out  1  one-cycle word strobe to the core.
- `in_data`  out  32  word to the core; valid while `shift_in_enable` is high, 0 otherwise.
- `sol_claim`  in  1  core reports a solution (level).
- `core_nonce`  in  32  core golden-nonce output.
- `sol_response`  out  1  one-cycle acknowledge to the core.

## Operation
- States: IDLE, START, SEND, WAIT, ACK, DONE.
- **IDLE**
  - `wr_en` with `!buf_full` stores `wr_data` at `buf[wr_count]` and increments `wr_count`.
  - `wr_en` while full, or in any other state, is ignored.
  - `job_go` with `buf_full` goes to START. `job_go` while not full is ignored.
- **START**
  - `start_found`=1 for exactly this one cycle.
  - Clear word index and gap counter; go to SEND.
- **SEND**
  - Emit words 0..23 in index order (words 0..7 midstate, 8..23 header).
  - Each word: `shift_in_enable`=1 and `in_data`=`buf[idx]` for one cycle, then `SHIFT_GAP` cycles with both outputs low/0.
  - After word 23's strobe go to WAIT directly; no trailing gap.
- **WAIT**
  - Cycle counter starts at 0 on entry and increments every WAIT cycle, saturating at 0xFFFFFFFF.
  - When `sol_claim` is sampled high: capture `core_nonce` to `result_nonce` and the counter to `result_cycles`, then go to ACK.
  - `sol_claim` is ignored in every state other than WAIT.
- **ACK**
  - `sol_response`=1 for this one cycle; go to DONE.
- **DONE**
  - `result_valid`=1, held until `result_ack` is sampled high.
  - Then: `wr_count`←0, clear `result_valid`, go to IDLE. Buffer contents are retained but unreadable.
  - `result_nonce`/`result_cycles` hold their values until the next capture.
- **abort** (any state): next state IDLE; `wr_count`←0; `result_valid`←0; `start_found`, `shift_in_enable`, `sol_response` low from the next cycle.
- `abort` has priority over `job_go`, `wr_en`, `sol_claim` and `result_ack` in the same cycle.

## Timing
- Reset values:
  - State IDLE; all outputs 0, including `wr_count`, `buf_full`, `busy`, `result_*`, `start_found`, `shift_in_enable`, `in_data`, `sol_response`.
  - Buffer contents are don't-care.
- Reset mid-operation clears everything immediately (asynchronous); the core is not sent `sol_response`.
- All outputs are registered; no combinational paths from inputs to outputs.
- Edge numbering: `job_go` sampled at edge E.
  - `start_found` is high in cycle E+1.
  - The first `shift_in_enable` is high in cycle E+2.
  - Strobe k is high in cycle E+2+k·(SHIFT_GAP+1).
- With `SHIFT_GAP`=0 the last strobe is in cycle E+25, and WAIT is entered in cycle E+26.
- `sol_claim` sampled high at WAIT cycle n (counter = n, first WAIT cycle n=0):
  - `result_cycles`=n.
  - `sol_response` is high in the next cycle.
  - `result_valid` rises the cycle after that.
- A write in the same cycle that `wr_count` reaches 24 is accepted. `buf_full` rises the next cycle.

## Test plan
- Reset, write 24 words 0x1000_0000+i, pulse `job_go` → `start_found` one cycle, then 24 back-to-back strobes with `in_data`=0x1000_0000..0x1000_0017 in order; `busy`=1.
- `SHIFT_GAP`=2, same job → strobes spaced 3 cycles apart; `in_data`=0 in the gap cycles; exactly 24 strobes.
- In WAIT, assert `sol_claim` at WAIT cycle 37 with `core_nonce`=0xDEADBEEF → one-cycle `sol_response`; `result_valid`=1, `result_nonce`=0xDEADBEEF, `result_cycles`=37; after `result_ack`, IDLE with `wr_count`=0.
- `job_go` with 23 words buffered → ignored, no `start_found`; a 25th `wr_en` after full → `wr_count` stays 24.
- `abort` at strobe 10 → no further strobes; `busy`=0 and `wr_count`=0 next cycle; a `sol_claim` that follows produces no `sol_response`.
- Deassert `n_rst` during WAIT → all outputs 0 asynchronously; a fresh job then dispatches normally.

Source files
------------

// File: rtl/job_dispatcher.sv
// Host-side job loader for the SHA core: buffers one 24-word job, streams it with
// start/shift strobes, waits for a solution claim, then holds nonce and latency for the host.
module job_dispatcher #(
   parameter int MID_WORDS  = 8,
   parameter int HEAD_WORDS = 16,
   parameter int SHIFT_GAP  = 0
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic [4:0]  wr_count,
   output logic        buf_full,
   input  logic        job_go,
   input  logic        abort,
   output logic        busy,
   output logic        result_valid,
   output logic [31:0] result_nonce,
   output logic [31:0] result_cycles,
   input  logic        result_ack,
   output logic        start_found,
   output logic        shift_in_enable,
   output logic [31:0] in_data,
   input  logic        sol_claim,
   input  logic [31:0] core_nonce,
   output logic        sol_response
);

   localparam int TOTAL = MID_WORDS + HEAD_WORDS;
   localparam int GAP_W = (SHIFT_GAP > 0) ? $clog2(SHIFT_GAP + 1) : 1;
   localparam logic [4:0]       TOTAL_C = 5'(TOTAL);
   localparam logic [GAP_W-1:0] GAP_C   = GAP_W'(SHIFT_GAP);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_SEND, S_WAIT, S_ACK, S_DONE
   } state_t;

   state_t state_q, state_n;

   logic [31:0]      job_buf [TOTAL];
   logic             we;
   logic [4:0]       wr_count_n;
   logic [4:0]       idx_q, idx_n;
   logic [GAP_W-1:0] gap_q, gap_n;
   logic [31:0]      cyc_q, cyc_n;
   logic [31:0]      nonce_n, rcyc_n;
   logic             valid_n, start_n, shift_n, resp_n;
   logic [31:0]      data_n;

   // Every output is the registered image of the next-state decision below, so
   // each one lines up with the state it belongs to and has no input-to-output path.
   // Result handshake: result_valid rises after a capture and stays high until
   // result_ack is sampled with it; result_ack without result_valid is ignored.
   always_comb begin
      state_n    = state_q;
      wr_count_n = wr_count;
      idx_n      = idx_q;
      gap_n      = gap_q;
      cyc_n      = cyc_q;
      nonce_n    = result_nonce;
      rcyc_n     = result_cycles;
      valid_n    = 1'b0;
      start_n    = 1'b0;
      shift_n    = 1'b0;
      data_n     = '0;
      resp_n     = 1'b0;
      we         = 1'b0;
      if (abort) begin
         state_n    = S_IDLE;
         wr_count_n = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (wr_en && (wr_count != TOTAL_C)) begin
                  we         = 1'b1;
                  wr_count_n = wr_count + 5'd1;
               end
               if (job_go && buf_full) begin
                  state_n = S_START;
                  start_n = 1'b1;
               end
            end
            S_START: begin
               state_n = S_SEND;
               shift_n = 1'b1;
               data_n  = job_buf[0];
               idx_n   = 5'd1;
               gap_n   = GAP_C;
            end
            S_SEND: begin
               // idx_q counts words already strobed; reaching TOTAL means the last strobe is on now
               if (idx_q == TOTAL_C) begin
                  state_n = S_WAIT;
                  cyc_n   = '0;
               end else if (gap_q == '0) begin
                  shift_n = 1'b1;
                  data_n  = job_buf[idx_q];
                  idx_n   = idx_q + 5'd1;
                  gap_n   = GAP_C;
               end else begin
                  gap_n = gap_q - GAP_ONE;
               end
            end
            S_WAIT: begin
               if (sol_claim) begin
                  nonce_n = core_nonce;
                  rcyc_n  = cyc_q;
                  resp_n  = 1'b1;
                  state_n = S_ACK;
               end else if (cyc_q != '1) begin
                  cyc_n = cyc_q + 32'd1;
               end
            end
            S_ACK: begin
               state_n = S_DONE;
               valid_n = 1'b1;
            end
            S_DONE: begin
               if (result_ack) begin
                  state_n    = S_IDLE;
                  wr_count_n = '0;
               end else begin
                  valid_n = 1'b1;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q         <= S_IDLE;
         wr_count        <= '0;
         buf_full        <= 1'b0;
         busy            <= 1'b0;
         idx_q           <= '0;
         gap_q           <= '0;
         cyc_q           <= '0;
         result_valid    <= 1'b0;
         result_nonce    <= '0;
         result_cycles   <= '0;
         start_found     <= 1'b0;
         shift_in_enable <= 1'b0;
         in_data         <= '0;
         sol_response    <= 1'b0;
      end else begin
         state_q         <= state_n;
         wr_count        <= wr_count_n;
         buf_full        <= (wr_count_n == TOTAL_C);
         busy            <= (state_n != S_IDLE);
         idx_q           <= idx_n;
         gap_q           <= gap_n;
         cyc_q           <= cyc_n;
         result_valid    <= valid_n;
         result_nonce    <= nonce_n;
         result_cycles   <= rcyc_n;
         start_found     <= start_n;
         shift_in_enable <= shift_n;
         in_data         <= data_n;
         sol_response    <= resp_n;
      end
   end

   // Job storage needs no reset; contents are only read after a full refill.
   always_ff @(posedge clk) begin
      if (we) job_buf[wr_count] <= wr_data;
   end

endmodule

// File: tb/tb_job_dispatcher.sv
// Directed bench for job_dispatcher: a back-to-back instance (d0) and a SHIFT_GAP=2
// instance (d1) share stimulus; outputs are checked on the falling edge.
module tb_job_dispatcher;

   logic        clk, n_rst;
   logic        wr_en, job_go, abort, result_ack, sol_claim;
   logic [31:0] wr_data, core_nonce;

   logic [4:0]  o0_wr_count, o1_wr_count;
   logic        o0_buf_full, o1_buf_full, o0_busy, o1_busy;
   logic        o0_valid, o1_valid, o0_start, o1_start, o0_shift, o1_shift;
   logic        o0_resp, o1_resp;
   logic [31:0] o0_nonce, o1_nonce, o0_cycles, o1_cycles, o0_data, o1_data;

   int tests = 0;
   int fails = 0;
   int s1_cnt = 0;

   job_dispatcher #(.MID_WORDS(8), .HEAD_WORDS(16), .SHIFT_GAP(0)) d0 (
      .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data),
      .wr_count(o0_wr_count), .buf_full(o0_buf_full), .job_go(job_go), .abort(abort),
      .busy(o0_busy), .result_valid(o0_valid), .result_nonce(o0_nonce),
      .result_cycles(o0_cycles), .result_ack(result_ack), .start_found(o0_start),
      .shift_in_enable(o0_shift), .in_data(o0_data), .sol_claim(sol_claim),
      .core_nonce(core_nonce), .sol_response(o0_resp)
   );

   job_dispatcher #(.MID_WORDS(8), .HEAD_WORDS(16), .SHIFT_GAP(2)) d1 (
      .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data),
      .wr_count(o1_wr_count), .buf_full(o1_buf_full), .job_go(job_go), .abort(abort),
      .busy(o1_busy), .result_valid(o1_valid), .result_nonce(o1_nonce),
      .result_cycles(o1_cycles), .result_ack(result_ack), .start_found(o1_start),
      .shift_in_enable(o1_shift), .in_data(o1_data), .sol_claim(sol_claim),
      .core_nonce(core_nonce), .sol_response(o1_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic pulse_go();
      job_go = 1'b1;
      @(negedge clk);
      job_go = 1'b0;
   endtask

   // i = cycles since the edge that sampled job_go
   task automatic chk_cycle0(input string tag, input int i, input logic [31:0] base);
      logic sh;
      sh = (i >= 2) && (i <= 25);
      chkb($sformatf("%s_sf0_c%0d", tag, i), o0_start, i == 1);
      chkb($sformatf("%s_se0_c%0d", tag, i), o0_shift, sh);
      chk($sformatf("%s_dat0_c%0d", tag, i), o0_data, sh ? base + 32'(i - 2) : 32'h0);
   endtask

   task automatic chk_cycle1(input string tag, input int i, input logic [31:0] base);
      logic sh;
      int   k;
      k  = i - 2;
      sh = (i >= 2) && (k % 3 == 0) && (k / 3 <= 23);
      chkb($sformatf("%s_sf1_c%0d", tag, i), o1_start, i == 1);
      chkb($sformatf("%s_se1_c%0d", tag, i), o1_shift, sh);
      chk($sformatf("%s_dat1_c%0d", tag, i), o1_data, sh ? base + 32'(k / 3) : 32'h0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wrc"}, 32'(o0_wr_count), 32'h0);
      chkb({tag, "_full"}, o0_buf_full, 1'b0);
      chkb({tag, "_busy"}, o0_busy, 1'b0);
      chkb({tag, "_valid"}, o0_valid, 1'b0);
      chk({tag, "_nonce"}, o0_nonce, 32'h0);
      chk({tag, "_cycles"}, o0_cycles, 32'h0);
      chkb({tag, "_start"}, o0_start, 1'b0);
      chkb({tag, "_shift"}, o0_shift, 1'b0);
      chk({tag, "_data"}, o0_data, 32'h0);
      chkb({tag, "_resp"}, o0_resp, 1'b0);
      chkb({tag, "_busy1"}, o1_busy, 1'b0);
      chk({tag, "_wrc1"}, 32'(o1_wr_count), 32'h0);
   endtask

   initial begin
      n_rst = 1'b0; wr_en = 1'b0; wr_data = '0; job_go = 1'b0; abort = 1'b0;
      result_ack = 1'b0; sol_claim = 1'b0; core_nonce = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("rst");
      n_rst = 1'b1;
      @(negedge clk);

      // Load and dispatch; claim at WAIT cycle 37 on the back-to-back instance
      for (int w = 0; w < 24; w++) begin
         write_word(32'h1000_0000 + 32'(w));
         if (w == 22) begin
            chk("wrc23", 32'(o0_wr_count), 32'd23);
            chkb("full23", o0_buf_full, 1'b0);
         end
      end
      chk("wrc24", 32'(o0_wr_count), 32'd24);
      chkb("full24", o0_buf_full, 1'b1);
      chkb("full24_d1", o1_buf_full, 1'b1);
      core_nonce = 32'hDEAD_BEEF;
      pulse_go();
      for (int i = 1; i <= 72; i++) begin
         chk_cycle0("p1", i, 32'h1000_0000);
         chk_cycle1("p1", i, 32'h1000_0000);
         chkb($sformatf("p1_busy0_c%0d", i), o0_busy, 1'b1);
         chkb($sformatf("p1_busy1_c%0d", i), o1_busy, 1'b1);
         chkb($sformatf("p1_resp0_c%0d", i), o0_resp, i == 64);
         chkb($sformatf("p1_valid0_c%0d", i), o0_valid, i >= 65);
         chkb($sformatf("p1_resp1_c%0d", i), o1_resp, 1'b0);
         if (o1_shift) s1_cnt++;
         sol_claim = (i == 63);
         @(negedge clk);
      end
      chk("gap_strobes", 32'(s1_cnt), 32'd24);
      chk("p1_nonce", o0_nonce, 32'hDEAD_BEEF);
      chk("p1_cycles", o0_cycles, 32'd37);
      chkb("p1_valid1", o1_valid, 1'b0);
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      chkb("ack_valid", o0_valid, 1'b0);
      chkb("ack_busy", o0_busy, 1'b0);
      chk("ack_wrc", 32'(o0_wr_count), 32'd0);
      chkb("ack_full", o0_buf_full, 1'b0);
      chk("ack_nonce_held", o0_nonce, 32'hDEAD_BEEF);
      chk("ack_cycles_held", o0_cycles, 32'd37);
      chkb("ack_busy1", o1_busy, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chkb("abort_busy1", o1_busy, 1'b0);
      chk("abort_wrc1", 32'(o1_wr_count), 32'd0);

      // Go with 23 words is ignored; a write past full is ignored
      for (int w = 0; w < 23; w++) write_word(32'h2000_0000 + 32'(w));
      pulse_go();
      for (int c = 0; c < 4; c++) begin
         chkb($sformatf("nogo_sf0_c%0d", c), o0_start, 1'b0);
         chkb($sformatf("nogo_busy0_c%0d", c), o0_busy, 1'b0);
         chkb($sformatf("nogo_sf1_c%0d", c), o1_start, 1'b0);
         @(negedge clk);
      end
      chk("nogo_wrc", 32'(o0_wr_count), 32'd23);
      write_word(32'h2000_0017);
      write_word(32'hBAD0_0000);
      chk("over_wrc", 32'(o0_wr_count), 32'd24);
      chkb("over_full", o0_buf_full, 1'b1);

      // Abort sampled during strobe 10
      pulse_go();
      for (int i = 1; i <= 12; i++) begin
         chk_cycle0("p3", i, 32'h2000_0000);
         chk_cycle1("p3", i, 32'h2000_0000);
         abort = (i == 12);
         @(negedge clk);
      end
      abort = 1'b0;
      chkb("ab_shift", o0_shift, 1'b0);
      chk("ab_data", o0_data, 32'h0);
      chkb("ab_busy", o0_busy, 1'b0);
      chk("ab_wrc", 32'(o0_wr_count), 32'd0);
      chkb("ab_busy1", o1_busy, 1'b0);
      sol_claim = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chkb($sformatf("ab_resp0_c%0d", c), o0_resp, 1'b0);
         chkb($sformatf("ab_shift0_c%0d", c), o0_shift, 1'b0);
         chkb($sformatf("ab_resp1_c%0d", c), o1_resp, 1'b0);
      end
      sol_claim = 1'b0;

      // Asynchronous reset while waiting for the core
      for (int w = 0; w < 24; w++) write_word(32'h3000_0000 + 32'(w));
      pulse_go();
      for (int i = 1; i <= 30; i++) begin
         chk_cycle0("p4", i, 32'h3000_0000);
         if (i < 30) @(negedge clk);
      end
      chkb("p4_busy_pre", o0_busy, 1'b1);
      #2 n_rst = 1'b0;
      #1 chk_all_zero("arst");
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // Fresh job after reset, claim on the very first WAIT cycle
      for (int w = 0; w < 24; w++) write_word(32'h4000_0000 + 32'(w));
      core_nonce = 32'h1234_5678;
      pulse_go();
      for (int i = 1; i <= 28; i++) begin
         chk_cycle0("p5", i, 32'h4000_0000);
         chk_cycle1("p5", i, 32'h4000_0000);
         chkb($sformatf("p5_resp0_c%0d", i), o0_resp, i == 27);
         chkb($sformatf("p5_valid0_c%0d", i), o0_valid, i >= 28);
         sol_claim = (i == 26);
         @(negedge clk);
      end
      sol_claim = 1'b0;
      chk("p5_nonce", o0_nonce, 32'h1234_5678);
      chk("p5_cycles", o0_cycles, 32'd0);
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      chkb("p5_ack_valid", o0_valid, 1'b0);
      chk("p5_ack_wrc", 32'(o0_wr_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
